load_check_queue: RTL and testbench

- Parametrised successor of the single-port load buffer. Tracks speculatively executed loads from allocation until commit.
- Snoops committed stores and flags every tracked load whose bytes a store overwrites.
- Sits between the load unit (allocation side) and the commit stage. The commit stage reads the per-load mis-speculation flag at retire.
- Adds over the previous generation: handshaked allocation, byte masks, all-match flagging, same-cycle store/commit forwarding, occupancy count.

---
 rtl/load_check_queue.sv | 121 ++++++++++++
 tb/tb_load_check_queue.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_check_queue.sv
// Load check queue: tracks speculative loads until commit and flags any that a committed store overwrites.
// Optional: define LCQ_SILENT_STORE_EN to ignore stores whose overlapping bytes match the loaded data.
module load_check_queue #(
   parameter  int DEPTH  = 8,
   parameter  int ADDR_W = 30,
   parameter  int DATA_W = 32,
   localparam int BYTES  = DATA_W / 8,
   localparam int TAG_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              kill,
   input  logic              alloc_valid,
   output logic              alloc_ready,
   output logic [TAG_W-1:0]  alloc_tag,
   input  logic [ADDR_W-1:0] alloc_addr,
   input  logic [BYTES-1:0]  alloc_mask,
   input  logic [DATA_W-1:0] alloc_data,
   input  logic              st_valid,
   input  logic [ADDR_W-1:0] st_addr,
   input  logic [BYTES-1:0]  st_mask,
   input  logic [DATA_W-1:0] st_data,
   input  logic              commit_valid,
   input  logic [TAG_W-1:0]  commit_tag,
   output logic              commit_misload,
   output logic [TAG_W:0]    count
);

   logic [DEPTH-1:0]  busy;
   logic [DEPTH-1:0]  miss;
   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [BYTES-1:0]  mask_q [DEPTH];
   logic [DEPTH-1:0]  st_flag;
   logic              alloc_flag;
   logic              fire;
   logic              commit_hit;

`ifdef LCQ_SILENT_STORE_EN
   logic [DATA_W-1:0] data_q [DEPTH];

   // Only lanes written by both the load and the store can make the store visible.
   function automatic logic lanes_differ(input logic [BYTES-1:0]  m,
                                         input logic [DATA_W-1:0] d,
                                         input logic [BYTES-1:0]  sm,
                                         input logic [DATA_W-1:0] sd);
      lanes_differ = 1'b0;
      for (int b = 0; b < BYTES; b++)
         if (m[b] && sm[b] && d[8*b +: 8] != sd[8*b +: 8])
            lanes_differ = 1'b1;
   endfunction
`else
   logic unused_data;
   assign unused_data = ^{alloc_data, st_data};
`endif

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      st_flag    = '0;
      alloc_flag = st_valid && alloc_addr == st_addr && |(alloc_mask & st_mask);
      for (int e = 0; e < DEPTH; e++) begin
         st_flag[e] = st_valid && busy[e] && addr_q[e] == st_addr && |(mask_q[e] & st_mask);
`ifdef LCQ_SILENT_STORE_EN
         st_flag[e] = st_flag[e] && lanes_differ(mask_q[e], data_q[e], st_mask, st_data);
`endif
      end
`ifdef LCQ_SILENT_STORE_EN
      alloc_flag = alloc_flag && lanes_differ(alloc_mask, alloc_data, st_mask, st_data);
`endif
   end

   always_comb begin
      alloc_tag = '0;
      for (int e = DEPTH - 1; e >= 0; e--)
         if (!busy[e])
            alloc_tag = TAG_W'(e);
   end

   assign alloc_ready    = count != (TAG_W + 1)'(DEPTH);
   assign fire           = alloc_valid && alloc_ready;
   assign commit_hit     = commit_valid && busy[commit_tag];
   assign commit_misload = commit_hit && (miss[commit_tag] || st_flag[commit_tag]);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy  <= '0;
         miss  <= '0;
         count <= '0;
      end else if (kill) begin
         busy  <= '0;
         miss  <= '0;
         count <= '0;
      end else begin
         for (int e = 0; e < DEPTH; e++)
            if (st_flag[e])
               miss[e] <= 1'b1;
         // Retire wins over a same-cycle store flag; the flag was already reported on commit_misload.
         if (commit_hit) begin
            busy[commit_tag] <= 1'b0;
            miss[commit_tag] <= 1'b0;
         end
         if (fire) begin
            busy[alloc_tag] <= 1'b1;
            miss[alloc_tag] <= alloc_flag;
         end
         count <= count + (TAG_W + 1)'(fire) - (TAG_W + 1)'(commit_hit);
      end
   end

   // NOTE: payload storage has no reset; it is only ever read qualified by busy.
   always_ff @(posedge clk) begin
      if (fire) begin
         addr_q[alloc_tag] <= alloc_addr;
         mask_q[alloc_tag] <= alloc_mask;
`ifdef LCQ_SILENT_STORE_EN
         data_q[alloc_tag] <= alloc_data;
`endif
      end
   end

endmodule

// File: tb/tb_load_check_queue.sv
// Self-checking bench for load_check_queue: directed scenarios plus randomized traffic
// compared against an entry-array reference model built from the queue's rules.
module tb_load_check_queue;

`ifdef LCQ_SILENT_STORE_EN
   localparam bit SILENT = 1'b1;
`else
   localparam bit SILENT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic        kill;
   logic        alloc_valid;
   logic        alloc_ready;
   logic [2:0]  alloc_tag;
   logic [29:0] alloc_addr;
   logic [3:0]  alloc_mask;
   logic [31:0] alloc_data;
   logic        st_valid;
   logic [29:0] st_addr;
   logic [3:0]  st_mask;
   logic [31:0] st_data;
   logic        commit_valid;
   logic [2:0]  commit_tag;
   logic        commit_misload;
   logic [3:0]  count;

   int n_checks = 0;
   int n_pass   = 0;

   bit          m_busy [8];
   bit          m_miss [8];
   logic [29:0] m_addr [8];
   logic [3:0]  m_mask [8];
   logic [31:0] m_data [8];

   load_check_queue #(.DEPTH(8), .ADDR_W(30), .DATA_W(32)) dut (
      .clk(clk), .reset_n(reset_n), .kill(kill),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
      .alloc_addr(alloc_addr), .alloc_mask(alloc_mask), .alloc_data(alloc_data),
      .st_valid(st_valid), .st_addr(st_addr), .st_mask(st_mask), .st_data(st_data),
      .commit_valid(commit_valid), .commit_tag(commit_tag),
      .commit_misload(commit_misload), .count(count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic bit m_store_hits(input logic [29:0] a, input logic [3:0] m, input logic [31:0] d);
      bit hit;
      bit differs;
      hit     = st_valid && a == st_addr && (m & st_mask) != 4'b0;
      differs = 1'b0;
      for (int b = 0; b < 4; b++)
         if (m[b] && st_mask[b] && d[8*b +: 8] != st_data[8*b +: 8])
            differs = 1'b1;
      return SILENT ? (hit && differs) : hit;
   endfunction

   function automatic int m_count();
      int n = 0;
      for (int i = 0; i < 8; i++) n += int'(m_busy[i]);
      return n;
   endfunction

   function automatic int m_first_free();
      for (int i = 0; i < 8; i++) if (!m_busy[i]) return i;
      return 0;
   endfunction

   function automatic bit m_misload();
      int t = int'(commit_tag);
      if (!commit_valid || !m_busy[t]) return 1'b0;
      return m_miss[t] || m_store_hits(m_addr[t], m_mask[t], m_data[t]);
   endfunction

   task automatic m_clear();
      for (int i = 0; i < 8; i++) begin
         m_busy[i] = 1'b0;
         m_miss[i] = 1'b0;
      end
   endtask

   // One clock edge: the model applies the same cycle's inputs in step with the DUT.
   task automatic tick();
      bit flags [8];
      bit fire;
      bit new_miss;
      bit retire;
      int tag;
      int ct;
      @(posedge clk);
      if (kill) begin
         m_clear();
      end else begin
         fire     = alloc_valid && m_count() < 8;
         tag      = m_first_free();
         ct       = int'(commit_tag);
         retire   = commit_valid && m_busy[ct];
         new_miss = m_store_hits(alloc_addr, alloc_mask, alloc_data);
         for (int i = 0; i < 8; i++) flags[i] = m_busy[i] && m_store_hits(m_addr[i], m_mask[i], m_data[i]);
         for (int i = 0; i < 8; i++) if (flags[i]) m_miss[i] = 1'b1;
         if (retire) begin
            m_busy[ct] = 1'b0;
            m_miss[ct] = 1'b0;
         end
         if (fire) begin
            m_busy[tag] = 1'b1;
            m_miss[tag] = new_miss;
            m_addr[tag] = alloc_addr;
            m_mask[tag] = alloc_mask;
            m_data[tag] = alloc_data;
         end
      end
      #1;
   endtask

   task automatic idle();
      kill = 0; alloc_valid = 0; alloc_addr = '0; alloc_mask = '0; alloc_data = '0;
      st_valid = 0; st_addr = '0; st_mask = '0; st_data = '0; commit_valid = 0; commit_tag = '0;
   endtask

   task automatic flush();
      idle(); kill = 1; tick(); idle();
   endtask

   task automatic do_alloc(input logic [29:0] a, input logic [3:0] m, input logic [31:0] d);
      idle(); alloc_valid = 1; alloc_addr = a; alloc_mask = m; alloc_data = d; tick(); idle();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      idle();
      reset_n = 0; commit_valid = 1; commit_tag = 3'd3;
      #1;
      n_checks++; if (count !== 4'd0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
      n_checks++; if (alloc_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", alloc_ready); else n_pass++;
      n_checks++; if (alloc_tag !== 3'd0) $display("FAIL reset_tag: got %0d want 0", alloc_tag); else n_pass++;
      n_checks++; if (commit_misload !== 1'b0) $display("FAIL reset_misload: got %b want 0", commit_misload); else n_pass++;
      idle();
      m_clear();
      @(negedge clk); reset_n = 1;
      @(posedge clk); #1;
   endtask

   task automatic test_fill();
      flush();
      for (int i = 0; i < 8; i++) begin
         alloc_valid = 1; alloc_addr = 30'(100 + i); alloc_mask = 4'hF; alloc_data = $urandom;
         #1;
         n_checks++; if (alloc_tag !== 3'(i)) $display("FAIL fill_tag%0d: got %0d want %0d", i, alloc_tag, i); else n_pass++;
         n_checks++; if (alloc_ready !== 1'b1) $display("FAIL fill_ready%0d: got %b want 1", i, alloc_ready); else n_pass++;
         tick();
      end
      idle();
      n_checks++; if (count !== 4'd8) $display("FAIL fill_count: got %0d want 8", count); else n_pass++;
      n_checks++; if (alloc_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", alloc_ready); else n_pass++;
      alloc_valid = 1; alloc_addr = 30'h7; alloc_mask = 4'hF;
      tick(); idle();
      n_checks++; if (count !== 4'd8) $display("FAIL ninth_alloc_count: got %0d want 8", count); else n_pass++;
      for (int i = 0; i < 8; i++) begin
         commit_valid = 1; commit_tag = 3'(i);
         #1;
         n_checks++; if (commit_misload !== 1'b0) $display("FAIL drain_misload%0d: got %b want 0", i, commit_misload); else n_pass++;
         tick();
      end
      idle();
      n_checks++; if (count !== 4'd0) $display("FAIL drain_count: got %0d want 0", count); else n_pass++;
   endtask

   task automatic test_no_overlap();
      flush();
      do_alloc(30'h10, 4'b0011, 32'h1234_5678);
      st_valid = 1; st_addr = 30'h10; st_mask = 4'b1100; st_data = 32'hFFFF_FFFF;
      tick(); idle();
      commit_valid = 1; commit_tag = 3'd0;
      #1;
      n_checks++; if (commit_misload !== 1'b0) $display("FAIL disjoint_lanes_misload: got %b want 0", commit_misload); else n_pass++;
      tick(); idle();
   endtask

   task automatic test_all_match();
      flush();
      for (int i = 0; i < 6; i++)
         if (i % 2 == 1) do_alloc(30'h20, 4'hF, 32'hAAAA_AAAA);
         else do_alloc(30'h40, 4'hF, 32'hAAAA_AAAA);
      st_valid = 1; st_addr = 30'h20; st_mask = 4'hF; st_data = 32'h5555_5555;
      tick(); idle();
      for (int i = 0; i < 6; i++) begin
         commit_valid = 1; commit_tag = 3'(i);
         #1;
         n_checks++;
         if (commit_misload !== 1'(i % 2)) $display("FAIL all_match_tag%0d: got %b want %0d", i, commit_misload, i % 2);
         else n_pass++;
         tick();
      end
      idle();
      n_checks++; if (count !== 4'd0) $display("FAIL all_match_count: got %0d want 0", count); else n_pass++;
   endtask

   task automatic test_store_commit_same_cycle();
      flush();
      do_alloc(30'h30, 4'hF, 32'h0000_1234);
      do_alloc(30'h31, 4'hF, 32'h0000_0000);
      st_valid = 1; st_addr = 30'h30; st_mask = 4'h1; st_data = 32'hFFFF_FFFF;
      commit_valid = 1; commit_tag = 3'd0;
      #1;
      n_checks++; if (commit_misload !== 1'b1) $display("FAIL store_commit_misload: got %b want 1", commit_misload); else n_pass++;
      tick(); idle();
      n_checks++; if (count !== 4'd1) $display("FAIL store_commit_count: got %0d want 1", count); else n_pass++;
      n_checks++; if (alloc_tag !== 3'd0) $display("FAIL store_commit_freed_tag: got %0d want 0", alloc_tag); else n_pass++;
   endtask

   task automatic test_alloc_store_same_cycle();
      flush();
      alloc_valid = 1; alloc_addr = 30'h50; alloc_mask = 4'b0110; alloc_data = 32'h1111_1111;
      st_valid = 1; st_addr = 30'h50; st_mask = 4'b0100; st_data = 32'h2222_2222;
      tick(); idle();
      commit_valid = 1; commit_tag = 3'd0;
      #1;
      n_checks++; if (commit_misload !== 1'b1) $display("FAIL alloc_store_misload: got %b want 1", commit_misload); else n_pass++;
      tick(); idle();
   endtask

   task automatic test_kill();
      flush();
      for (int i = 0; i < 5; i++) do_alloc(30'(i), 4'hF, 32'h0);
      st_valid = 1; st_addr = 30'h1; st_mask = 4'hF; st_data = 32'h1;
      tick(); idle();
      n_checks++; if (count !== 4'd5) $display("FAIL prekill_count: got %0d want 5", count); else n_pass++;
      kill = 1; alloc_valid = 1; alloc_addr = 30'h9; alloc_mask = 4'hF;
      commit_valid = 1; commit_tag = 3'd2; st_valid = 1; st_addr = 30'h3; st_mask = 4'hF; st_data = 32'h7;
      tick(); idle();
      n_checks++; if (count !== 4'd0) $display("FAIL kill_count: got %0d want 0", count); else n_pass++;
      n_checks++; if (alloc_tag !== 3'd0) $display("FAIL kill_tag: got %0d want 0", alloc_tag); else n_pass++;
      n_checks++; if (alloc_ready !== 1'b1) $display("FAIL kill_ready: got %b want 1", alloc_ready); else n_pass++;
      commit_valid = 1; commit_tag = 3'd1;
      #1;
      n_checks++; if (commit_misload !== 1'b0) $display("FAIL kill_flag_cleared: got %b want 0", commit_misload); else n_pass++;
      tick(); idle();
   endtask

   task automatic test_silent_store();
      flush();
      do_alloc(30'h60, 4'hF, 32'hCAFE_F00D);
      do_alloc(30'h61, 4'hF, 32'hCAFE_F00D);
      st_valid = 1; st_addr = 30'h60; st_mask = 4'hF; st_data = 32'hCAFE_F00D;
      tick(); idle();
      st_valid = 1; st_addr = 30'h61; st_mask = 4'b0001; st_data = 32'h0000_000D;
      tick(); idle();
      for (int i = 0; i < 2; i++) begin
         commit_valid = 1; commit_tag = 3'(i);
         #1;
         n_checks++;
         if (commit_misload !== !SILENT) $display("FAIL silent_store%0d: got %b want %b", i, commit_misload, !SILENT);
         else n_pass++;
         tick();
      end
      idle();
   endtask

   task automatic test_random();
      flush();
      for (int cyc = 0; cyc < 600; cyc++) begin
         kill         = ($urandom_range(0, 39) == 0);
         alloc_valid  = ($urandom_range(0, 1) == 1);
         alloc_addr   = 30'($urandom_range(0, 3));
         alloc_mask   = 4'($urandom);
         alloc_data   = ($urandom_range(0, 1) == 1) ? 32'hAAAA_AAAA : 32'hAA55_AA55;
         st_valid     = ($urandom_range(0, 4) < 2);
         st_addr      = 30'($urandom_range(0, 3));
         st_mask      = 4'($urandom);
         st_data      = ($urandom_range(0, 1) == 1) ? 32'hAAAA_AAAA : 32'h5555_AA55;
         commit_valid = ($urandom_range(0, 4) < 2);
         commit_tag   = 3'($urandom);
         #2;
         n_checks++;
         if (count !== 4'(m_count())) $display("FAIL rnd_count@%0d: got %0d want %0d", cyc, count, m_count());
         else n_pass++;
         n_checks++;
         if (alloc_ready !== (m_count() != 8)) $display("FAIL rnd_ready@%0d: got %b want %b", cyc, alloc_ready, m_count() != 8);
         else n_pass++;
         if (m_count() != 8) begin
            n_checks++;
            if (alloc_tag !== 3'(m_first_free())) $display("FAIL rnd_tag@%0d: got %0d want %0d", cyc, alloc_tag, m_first_free());
            else n_pass++;
         end
         n_checks++;
         if (commit_misload !== m_misload()) $display("FAIL rnd_misload@%0d: got %b want %b", cyc, commit_misload, m_misload());
         else n_pass++;
         tick();
      end
      idle();
   endtask

   task automatic test_async_reset();
      flush();
      do_alloc(30'h70, 4'hF, 32'h0);
      do_alloc(30'h71, 4'hF, 32'h0);
      do_alloc(30'h72, 4'hF, 32'h0);
      st_valid = 1; st_addr = 30'h71; st_mask = 4'hF; st_data = 32'hF;
      tick(); idle();
      commit_valid = 1; commit_tag = 3'd1;
      #1;
      n_checks++; if (commit_misload !== 1'b1) $display("FAIL prereset_misload: got %b want 1", commit_misload); else n_pass++;
      #1 reset_n = 0;
      #1;
      n_checks++; if (count !== 4'd0) $display("FAIL async_reset_count: got %0d want 0", count); else n_pass++;
      n_checks++; if (alloc_ready !== 1'b1) $display("FAIL async_reset_ready: got %b want 1", alloc_ready); else n_pass++;
      n_checks++; if (alloc_tag !== 3'd0) $display("FAIL async_reset_tag: got %0d want 0", alloc_tag); else n_pass++;
      n_checks++; if (commit_misload !== 1'b0) $display("FAIL async_reset_misload: got %b want 0", commit_misload); else n_pass++;
      idle();
      m_clear();
      @(negedge clk); reset_n = 1;
      @(posedge clk); #1;
   endtask

   initial begin
      idle();
      reset_n = 0;
      test_reset();
      test_fill();
      test_no_overlap();
      test_all_match();
      test_store_commit_same_cycle();
      test_alloc_store_same_cycle();
      test_kill();
      test_silent_store();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
